ptp_bridge_rx_dbg_csr: RTL
==========================

# ptp_bridge_rx_dbg_csr

Debug CSR bank for one PTP bridge RX path. It sits directly downstream of the RX AVMM address checker and consumes that block's registered, region-qualified, base-relative request (`avmm_*_c1`). It keeps eight saturating 32-bit event counters, a max-frame-length tracker, scratch/control/status registers and a software snapshot mechanism. It returns read data with fixed one-cycle latency to the bridge's debug read mux.

## Interface
- `INST_ID`, 0: RX path index; reflected in the ID register.
- `ADDR_WIDTH`, 16: width of the base-relative byte address.
- `DATA_WIDTH`, 32: AVMM data width; only 32 is supported.
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: reset, synchronous, active-low.
- `avmm_address_c1` input ADDR_WIDTH: byte offset from region base.
- `avmm_read_c1` input 1: read strobe, one cycle per request.
- `avmm_write_c1` input 1: write strobe, one cycle per request.
- `avmm_writedata_c1` input 32: write data.
- `avmm_byteenable_c1` input 4: byte enables.
- `avmm_readdata` output 32: read data.
- `avmm_readdatavalid` output 1: one-cycle pulse qualifying `avmm_readdata`.
- `rx_evt` input 8: per-cycle increment pulses. Bit order: sop, eop, ptp_1step, ptp_2step, crc_err, drop, fifo_ovf, ts_miss.
- `rx_frame_len_vld` input 1: qualifies `rx_frame_len`.
- `rx_frame_len` input 16: length of the completed frame, in bytes.

## Operation
- Decode uses word index `avmm_address_c1[5:2]`. If any of bits [ADDR_WIDTH-1:6] is nonzero, the access is a miss: a read returns 0 (still valid), a write is ignored. Bits [1:0] are ignored.
- Register map:
  - 0x00 ID, RO: `{16'h5258, 8'h00, INST_ID[7:0]}`.
  - 0x04 SCRATCH, RW, reset 0. Per-byte byteenable is honoured.
  - 0x08 CTRL:
    - bit0 SNAP: write-1, self-clearing, reads 0.
    - bit1 CLR: write-1, self-clearing, reads 0.
    - bit2 CNT_EN: RW, reset 1.
    - Writes to CTRL and STATUS take effect only if byteenable[0]=1.
  - 0x0C STATUS, W1C: bits[7:0] are the sticky saturation flags of counters 7..0. Bits above 7 read 0.
  - 0x10–0x2C SNAP_CNT0..7, RO: snapshot copies of live counters 0..7.
  - 0x30 SNAP_MAXLEN, RO: `{16'h0, snapshot of max frame length}`.
  - 0x34–0x3C reserved: read 0, writes ignored.
- Live counters are not directly readable. Software writes SNAP, then reads the SNAP_* registers.
- Counter i increments by 1 in a cycle with `rx_evt[i]=1` and CNT_EN=1.
  - At 0xFFFF_FFFF it holds its value and sets STATUS[i] instead of wrapping.
- Max-length tracker: on `rx_frame_len_vld`, if `rx_frame_len` > current max, load it. Equal values leave it unchanged.
- CLR zeroes all live counters and the live max. It does not touch snapshots, STATUS, SCRATCH or CNT_EN.
- Precedence rules:
  - CLR beats an increment in the same cycle: the counter becomes 0.
  - SNAP and CLR in the same write: the snapshot captures pre-clear values, then live values are cleared.
  - A STATUS W1C in the same cycle as a new saturation event: the set wins.
  - `avmm_read_c1` and `avmm_write_c1` both high: the read is serviced and the write is dropped.
- Live counter i at 0xFFFF_FFFF with `rx_evt[i]`=1 and CNT_EN=0: no change, STATUS unaffected.

## Timing
- Read: request in cycle N → `avmm_readdatavalid`=1 with data in cycle N+1. Back-to-back reads on consecutive cycles are supported. No waitrequest exists.
- Write: the register updates at the clock edge ending cycle N, so it is visible to a read issued in N+1.
- SNAP write in cycle N: snapshot registers load live values as they stand at the end of cycle N. Events in cycle N are included.
- Events: `rx_evt` sampled in cycle N is reflected in the live counter at N+1. The tracker updates at N+1 as well.
- Reset (`rst_n`=0 sampled at an edge) sets, at that edge:
  - `avmm_readdata`=0, `avmm_readdatavalid`=0.
  - All live and snapshot counters, max length, STATUS and SCRATCH = 0.
  - CNT_EN=1.
- A read in flight when reset asserts produces no `avmm_readdatavalid`.
- Inputs are ignored while `rst_n`=0.

## Test plan
- Reset, then read 0x00 and 0x08 with INST_ID=1 → readdata 0x5258_0001 then 0x0000_0004, each valid exactly one cycle after the request.
- Pulse `rx_evt[0]` 5 cycles and `rx_evt[4]` 2 cycles, write CTRL=0x1, read 0x10 and 0x20 → 5 and 2. A further event without SNAP leaves the read values unchanged.
- Force counter 3 to 0xFFFF_FFFE, pulse `rx_evt[3]` 3 times, SNAP → SNAP_CNT3=0xFFFF_FFFF, STATUS=0x08.
  - Write STATUS=0x08 in the same cycle as another `rx_evt[3]` → STATUS stays 0x08.
  - Next clean W1C → 0x00.
- Write CTRL=0x3 in the same cycle as `rx_evt[1]` with live cnt1=7 → SNAP_CNT1=8. A later SNAP gives 0.
- Frame lengths 64, 1518, 1518, 128 with valid → SNAP_MAXLEN=0x5EE. Write SCRATCH=0xA5A5_A5A5 with be=4'b0010 from 0 → readback 0x0000_A500.
- Read to offset 0x140 (bit 8 set) → readdata 0 with valid. Simultaneous read+write to SCRATCH → SCRATCH unchanged. Assert `rst_n`=0 the cycle after a read request → no valid pulse, all counters read 0 after reset.

Source files
------------

// File: rtl/ptp_bridge_rx_dbg_csr.sv
// Debug CSR bank for one PTP bridge RX path: saturating event counters, max frame
// length tracker, scratch/control/status registers and a software-triggered snapshot.
module ptp_bridge_rx_dbg_csr #(
  parameter int unsigned INST_ID    = 0,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   avmm_address_c1,
  input  logic                    avmm_read_c1,
  input  logic                    avmm_write_c1,
  input  logic [DATA_WIDTH-1:0]   avmm_writedata_c1,
  input  logic [DATA_WIDTH/8-1:0] avmm_byteenable_c1,
  output logic [DATA_WIDTH-1:0]   avmm_readdata,
  output logic                    avmm_readdatavalid,
  input  logic [7:0]              rx_evt,
  input  logic                    rx_frame_len_vld,
  input  logic [15:0]             rx_frame_len
);

  localparam logic [3:0] REG_ID      = 4'h0;
  localparam logic [3:0] REG_SCRATCH = 4'h1;
  localparam logic [3:0] REG_CTRL    = 4'h2;
  localparam logic [3:0] REG_STATUS  = 4'h3;
  localparam logic [3:0] REG_MAXLEN  = 4'hC;
  localparam logic [DATA_WIDTH-1:0] ID_VAL = {16'h5258, 8'h00, 8'(INST_ID)};

  logic [31:0]           cnt_q [8];
  logic [31:0]           cnt_d [8];
  logic [31:0]           cnt_live [8];
  logic [31:0]           snap_cnt_q [8];
  logic [31:0]           snap_cnt_d [8];
  logic [15:0]           max_q, max_d, max_live;
  logic [15:0]           snap_max_q, snap_max_d;
  logic [7:0]            status_q, status_d, sat_set;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic                  cnt_en_q, cnt_en_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
  logic                  rvalid_q, rvalid_d;

  logic       hit, wr_en, ctrl_wr, status_wr, snap, clr;
  logic [3:0] word;
  logic [1:0] unused_addr_lsb;

  assign unused_addr_lsb = avmm_address_c1[1:0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hit        = (avmm_address_c1[ADDR_WIDTH-1:6] == '0);
    word       = avmm_address_c1[5:2];
    // A colliding read wins; the write is simply dropped.
    wr_en      = avmm_write_c1 & ~avmm_read_c1 & hit;
    ctrl_wr    = wr_en && (word == REG_CTRL) && avmm_byteenable_c1[0];
    status_wr  = wr_en && (word == REG_STATUS) && avmm_byteenable_c1[0];
    snap       = ctrl_wr & avmm_writedata_c1[0];
    clr        = ctrl_wr & avmm_writedata_c1[1];

    sat_set    = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_live[i] = cnt_q[i];
      if (rx_evt[i] && cnt_en_q) begin
        if (&cnt_q[i]) sat_set[i] = 1'b1;
        else           cnt_live[i] = cnt_q[i] + 32'd1;
      end
      // Snapshot sees this cycle's events but not the clear.
      snap_cnt_d[i] = snap ? cnt_live[i] : snap_cnt_q[i];
      cnt_d[i]      = clr  ? '0          : cnt_live[i];
    end

    max_live   = (rx_frame_len_vld && (rx_frame_len > max_q)) ? rx_frame_len : max_q;
    snap_max_d = snap ? max_live : snap_max_q;
    max_d      = clr  ? '0       : max_live;

    status_d   = (status_q & ~(status_wr ? avmm_writedata_c1[7:0] : 8'h00)) | sat_set;
    cnt_en_d   = ctrl_wr ? avmm_writedata_c1[2] : cnt_en_q;

    scratch_d  = scratch_q;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (wr_en && (word == REG_SCRATCH) && avmm_byteenable_c1[b])
        scratch_d[8*b +: 8] = avmm_writedata_c1[8*b +: 8];
    end

    rd_mux = '0;
    if (hit) begin
      case (word)
        REG_ID:      rd_mux = ID_VAL;
        REG_SCRATCH: rd_mux = scratch_q;
        REG_CTRL:    rd_mux = {29'd0, cnt_en_q, 2'b00};
        REG_STATUS:  rd_mux = {24'd0, status_q};
        4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB:
                     rd_mux = snap_cnt_q[3'(word - 4'd4)];
        REG_MAXLEN:  rd_mux = {16'd0, snap_max_q};
        default:     rd_mux = '0;
      endcase
    end
    rdata_d  = avmm_read_c1 ? rd_mux : '0;
    rvalid_d = avmm_read_c1;
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the counter and snapshot arrays are plain flops, so they are reset like any other state.
      for (int i = 0; i < 8; i++) begin
        cnt_q[i]      <= '0;
        snap_cnt_q[i] <= '0;
      end
      max_q      <= '0;
      snap_max_q <= '0;
      status_q   <= '0;
      scratch_q  <= '0;
      cnt_en_q   <= 1'b1;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i]      <= cnt_d[i];
        snap_cnt_q[i] <= snap_cnt_d[i];
      end
      max_q      <= max_d;
      snap_max_q <= snap_max_d;
      status_q   <= status_d;
      scratch_q  <= scratch_d;
      cnt_en_q   <= cnt_en_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign avmm_readdata      = rdata_q;
  assign avmm_readdatavalid = rvalid_q;

endmodule
